// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer and hazard controller for a five-stage pipeline.
// It chooses the next fetch address, stalls fetch/decode on a load-use hazard,
// flushes IF/ID and bubbles ID/EX on a taken branch, and freezes fetch while
// halted. It also counts stall and flush events with saturating counters.
//
// Ports
//   clk            in   1   sole clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   Halt           in   1   request to freeze fetch (taken in RUN)
//   Resume         in   1   release from halt (wins over Halt in HALTED)
//   ID_EX_MemRead  in   1   instruction in EX is a load
//   ID_EX_Rd       in   5   destination register of the EX instruction
//   IF_ID_Rs1      in   5   first source register of the ID instruction
//   IF_ID_Rs2      in   5   second source register of the ID instruction
//   Branch_Taken   in   1   taken branch/jump resolved in EX
//   Branch_Target  in  64   redirect address
//   PC_Current     in  64   present program counter value
//   PC_Write       out  1   program counter load enable
//   PC_Next        out 64   next program counter value
//   IF_ID_Write    out  1   IF/ID register enable
//   IF_ID_Flush    out  1   IF/ID register clear
//   ID_EX_Bubble   out  1   zero the control signals entering ID/EX
//   Stall_Count    out 16   saturating count of load-use stall cycles
//   Flush_Count    out 16   saturating count of branch redirect cycles
// -----------------------------------------------------------------------------
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        Halt,
  input  logic        Resume,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  ID_EX_Rd,
  input  logic [4:0]  IF_ID_Rs1,
  input  logic [4:0]  IF_ID_Rs2,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic [63:0] PC_Current,
  output logic        PC_Write,
  output logic [63:0] PC_Next,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Bubble,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_load_use;
  logic        w_stall_evt;
  logic        w_flush_evt;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  // Register x0 is hard-wired to zero, so a load targeting it never creates
  // a real dependency.
  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                      ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));

  // State register. Because reset forces BOOT asynchronously and every output
  // below is decoded from the state, the outputs take their reset values the
  // moment reset asserts, with no clock edge needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
    end else begin
      // NOTE: non-blocking assignment for every flop so all state updates
      // see pre-edge values regardless of process ordering.
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would infer a latch. The defaults are the
    // "frozen" values shared by BOOT and HALTED.
    w_next_state = r_state;
    PC_Next      = PC_Current + 64'd4;  // wraps modulo 2^64 naturally
    PC_Write     = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b1;
    w_stall_evt  = 1'b0;
    w_flush_evt  = 1'b0;

    unique case (r_state)
      ST_BOOT: begin
        // One frozen cycle after reset release, then start fetching.
        w_next_state = ST_RUN;
      end

      ST_RUN: begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        // A taken branch discards the ID instruction anyway, so any load-use
        // hazard against it is moot: redirect wins and no stall is counted.
        if (Branch_Taken) begin
          PC_Next      = Branch_Target;
          IF_ID_Flush  = 1'b1;
          ID_EX_Bubble = 1'b1;
          w_flush_evt  = 1'b1;
        end else if (w_load_use) begin
          // The bubble clears ID_EX_MemRead next cycle, ending the stall.
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          w_stall_evt  = 1'b1;
        end
        if (Halt) begin
          w_next_state = ST_HALTED;
        end
      end

      ST_HALTED: begin
        // Resume has priority over a still-asserted Halt.
        if (Resume) begin
          w_next_state = ST_RUN;
        end
      end

      default: begin
        w_next_state = ST_BOOT;
      end
    endcase
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall_evt && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_flush_evt && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign Stall_Count = r_stall_count;
  assign Flush_Count = r_flush_count;

endmodule
